ctrl_pipe_hazard: RTL and testbench

- Receiving end of the main decoder's control bundle.
- Carries RegWrite/MemtoReg/MemRead/MemWrite/ALUOp/ALUSrc/Branch plus register indices through the ID/EX, EX/MEM and MEM/WB stages of the 5-stage RISC-V datapath.
- Detects load-use hazards (stall + bubble), squashes on taken branch, and generates EX-stage forwarding selects.
- Counts stall and flush events for the performance testbench.

---
 rtl/ctrl_pipe_hazard.sv | 138 +++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard.sv
// Control-bundle pipeline for the 5-stage RISC-V datapath.
// Carries the decoder controls from ID through EX, MEM and WB.
// Stalls on load-use and squashes on taken branch by inserting a zero bundle into ID/EX.
// Produces EX-stage forwarding selects and keeps saturating stall/flush event counters.
module ctrl_pipe_hazard #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic             id_regwrite_i,
  input  logic             id_memtoreg_i,
  input  logic             id_memread_i,
  input  logic             id_memwrite_i,
  input  logic [1:0]       id_aluop_i,
  input  logic             id_alusrc_i,
  input  logic             id_branch_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [1:0]       ex_aluop_o,
  output logic             ex_alusrc_o,
  output logic             ex_branch_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_memread_o,
  output logic             mem_memwrite_o,
  output logic             wb_regwrite_o,
  output logic             wb_memtoreg_o,
  output logic [4:0]       wb_rd_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic [1:0] aluOp;
    logic       aluSrc;
    logic       branch;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idExT;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic [4:0] rd;
  } exMemT;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic [4:0] rd;
  } memWbT;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  idExT  idEx;
  idExT  idBundle;
  exMemT exMem;
  memWbT memWb;
  logic  loadUse;
  logic  insertBubble;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // Load-use: the load in EX writes a register the ID instruction reads; x0 is never a hazard.
  assign loadUse = id_valid_i & idEx.memRead & (idEx.rd != 5'd0) &
                   ((idEx.rd == id_rs1_i) | (idEx.rd == id_rs2_i));

  // Stall, flush and an empty ID slot all collapse into one bubble into ID/EX.
  assign insertBubble = loadUse | flush_i | ~id_valid_i;

  assign idBundle = '{regWrite: id_regwrite_i, memToReg: id_memtoreg_i,
                      memRead: id_memread_i, memWrite: id_memwrite_i,
                      aluOp: id_aluop_i, aluSrc: id_alusrc_i, branch: id_branch_i,
                      rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i};

  // Advance all three pipeline registers every cycle; a zero bundle is a bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else begin
      idEx  <= insertBubble ? '0 : idBundle;
      exMem <= '{regWrite: idEx.regWrite, memToReg: idEx.memToReg,
                 memRead: idEx.memRead, memWrite: idEx.memWrite, rd: idEx.rd};
      memWb <= '{regWrite: exMem.regWrite, memToReg: exMem.memToReg, rd: exMem.rd};
    end
  end

  // Count stall and flush cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (loadUse && (stallCnt != CntMax)) stallCnt <= stallCnt + 1'b1;
      if (flush_i && (flushCnt != CntMax)) flushCnt <= flushCnt + 1'b1;
    end
  end

  // Forwarding selects: EX/MEM wins over MEM/WB because it holds the newer value.
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (exMem.regWrite && (exMem.rd != 5'd0) && (exMem.rd == idEx.rs1))
      fwd_a_o = 2'b10;
    else if (memWb.regWrite && (memWb.rd != 5'd0) && (memWb.rd == idEx.rs1))
      fwd_a_o = 2'b01;
    if (exMem.regWrite && (exMem.rd != 5'd0) && (exMem.rd == idEx.rs2))
      fwd_b_o = 2'b10;
    else if (memWb.regWrite && (memWb.rd != 5'd0) && (memWb.rd == idEx.rs2))
      fwd_b_o = 2'b01;
  end

  assign stall_o        = loadUse;
  assign ex_aluop_o     = idEx.aluOp;
  assign ex_alusrc_o    = idEx.aluSrc;
  assign ex_branch_o    = idEx.branch;
  assign mem_memread_o  = exMem.memRead;
  assign mem_memwrite_o = exMem.memWrite;
  assign wb_regwrite_o  = memWb.regWrite;
  assign wb_memtoreg_o  = memWb.memToReg;
  assign wb_rd_o        = memWb.rd;
  assign stall_cnt_o    = stallCnt;
  assign flush_cnt_o    = flushCnt;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: latency, load-use stall, flush, forwarding and
// counter saturation (second instance built with 1-bit counters).
module tb_ctrl_pipe_hazard;

  logic clk = 1'b0;
  logic rstN;
  logic idValid, idRegWrite, idMemToReg, idMemRead, idMemWrite, idAluSrc, idBranch;
  logic [1:0] idAluOp;
  logic [4:0] idRs1, idRs2, idRd;
  logic flush;

  logic stall, exAluSrc, exBranch, memMemRead, memMemWrite, wbRegWrite, wbMemToReg;
  logic [1:0] exAluOp, fwdA, fwdB;
  logic [4:0] wbRd;
  logic [31:0] stallCnt, flushCnt;

  logic stall1, exAluSrc1, exBranch1, memMemRead1, memMemWrite1, wbRegWrite1, wbMemToReg1;
  logic [1:0] exAluOp1, fwdA1, fwdB1;
  logic [4:0] wbRd1;
  logic [0:0] stallCnt1, flushCnt1;

  int checks = 0;
  int failures = 0;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  ctrl_pipe_hazard #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rstN), .id_valid_i(idValid), .id_regwrite_i(idRegWrite),
    .id_memtoreg_i(idMemToReg), .id_memread_i(idMemRead), .id_memwrite_i(idMemWrite),
    .id_aluop_i(idAluOp), .id_alusrc_i(idAluSrc), .id_branch_i(idBranch),
    .id_rs1_i(idRs1), .id_rs2_i(idRs2), .id_rd_i(idRd), .flush_i(flush),
    .stall_o(stall), .ex_aluop_o(exAluOp), .ex_alusrc_o(exAluSrc), .ex_branch_o(exBranch),
    .fwd_a_o(fwdA), .fwd_b_o(fwdB), .mem_memread_o(memMemRead), .mem_memwrite_o(memMemWrite),
    .wb_regwrite_o(wbRegWrite), .wb_memtoreg_o(wbMemToReg), .wb_rd_o(wbRd),
    .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
  );

  ctrl_pipe_hazard #(.CNT_W(1)) dut1 (
    .clk_i(clk), .rst_i(rstN), .id_valid_i(idValid), .id_regwrite_i(idRegWrite),
    .id_memtoreg_i(idMemToReg), .id_memread_i(idMemRead), .id_memwrite_i(idMemWrite),
    .id_aluop_i(idAluOp), .id_alusrc_i(idAluSrc), .id_branch_i(idBranch),
    .id_rs1_i(idRs1), .id_rs2_i(idRs2), .id_rd_i(idRd), .flush_i(flush),
    .stall_o(stall1), .ex_aluop_o(exAluOp1), .ex_alusrc_o(exAluSrc1), .ex_branch_o(exBranch1),
    .fwd_a_o(fwdA1), .fwd_b_o(fwdB1), .mem_memread_o(memMemRead1), .mem_memwrite_o(memMemWrite1),
    .wb_regwrite_o(wbRegWrite1), .wb_memtoreg_o(wbMemToReg1), .wb_rd_o(wbRd1),
    .stall_cnt_o(stallCnt1), .flush_cnt_o(flushCnt1)
  );

  task automatic applyStimulus(input logic v, input logic rw, input logic m2r, input logic mr,
                               input logic mw, input logic [1:0] op, input logic src,
                               input logic br, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic fl);
    idValid = v; idRegWrite = rw; idMemToReg = m2r; idMemRead = mr; idMemWrite = mw;
    idAluOp = op; idAluSrc = src; idBranch = br; idRs1 = rs1; idRs2 = rs2; idRd = rd;
    flush = fl;
  endtask

  task automatic applyNop();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence; inputs change 1 unit after a rising edge, outputs are sampled there too.
  initial begin
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 5'd1, 5'd2, 5'd9, 1'b0);
    tick(2);
    checkOutput("rst_ex_aluop", {30'd0, exAluOp}, 32'd0);
    checkOutput("rst_ex_alusrc", {31'd0, exAluSrc}, 32'd0);
    checkOutput("rst_ex_branch", {31'd0, exBranch}, 32'd0);
    checkOutput("rst_wb_regwrite", {31'd0, wbRegWrite}, 32'd0);
    checkOutput("rst_wb_rd", {27'd0, wbRd}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_stall_cnt", stallCnt, 32'd0);
    checkOutput("rst_flush_cnt", flushCnt, 32'd0);

    // Release reset: the held bundle reaches EX next edge, WB three edges later.
    rstN = 1'b1;
    tick(1);
    checkOutput("lat_ex_aluop", {30'd0, exAluOp}, 32'd2);
    checkOutput("lat_ex_alusrc", {31'd0, exAluSrc}, 32'd1);
    checkOutput("lat_ex_branch", {31'd0, exBranch}, 32'd1);
    applyNop();
    tick(1);
    checkOutput("lat_ex_bubble", {30'd0, exAluOp}, 32'd0);
    tick(1);
    checkOutput("lat_wb_regwrite", {31'd0, wbRegWrite}, 32'd1);
    checkOutput("lat_wb_memtoreg", {31'd0, wbMemToReg}, 32'd1);
    checkOutput("lat_wb_rd", {27'd0, wbRd}, 32'd9);
    tick(2);

    // lw x5 followed by add rs1=x5: one stall cycle, then MEM/WB forwarding.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd1, 5'd0, 5'd5, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd5, 5'd6, 5'd8, 1'b0);
    #1;
    checkOutput("lu_stall_on", {31'd0, stall}, 32'd1);
    tick(1);
    checkOutput("lu_ex_bubble", {30'd0, exAluOp}, 32'd0);
    checkOutput("lu_mem_memread", {31'd0, memMemRead}, 32'd1);
    checkOutput("lu_stall_cnt", stallCnt, 32'd1);
    #1;
    checkOutput("lu_stall_off", {31'd0, stall}, 32'd0);
    tick(1);
    checkOutput("lu_ex_add", {30'd0, exAluOp}, 32'd2);
    checkOutput("lu_fwd_a", {30'd0, fwdA}, 32'd1);
    checkOutput("lu_fwd_b", {30'd0, fwdB}, 32'd0);
    checkOutput("lu_stall_cnt_hold", stallCnt, 32'd1);
    applyNop();
    tick(3);

    // add x3 then sub rs2=x3 back to back: EX/MEM forwarding on B, no stall.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd4, 5'd3, 5'd10, 1'b0);
    #1;
    checkOutput("fb_no_stall", {31'd0, stall}, 32'd0);
    tick(1);
    checkOutput("fb_exmem_b", {30'd0, fwdB}, 32'd2);
    checkOutput("fb_exmem_a", {30'd0, fwdA}, 32'd0);
    applyNop();
    tick(3);

    // Same pair with one nop between: MEM/WB forwarding on B.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
    tick(1);
    applyNop();
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd4, 5'd3, 5'd10, 1'b0);
    tick(1);
    checkOutput("fb_memwb_b", {30'd0, fwdB}, 32'd1);
    applyNop();
    tick(3);

    // Two producers of x7 in flight: the newer one (EX/MEM) wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd1, 5'd2, 5'd7, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd2, 5'd1, 5'd7, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd7, 5'd0, 5'd11, 1'b0);
    tick(1);
    checkOutput("fa_priority", {30'd0, fwdA}, 32'd2);
    applyNop();
    tick(3);

    // Producer writes x0: never forwarded.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 5'd0, 5'd12, 1'b0);
    tick(1);
    checkOutput("fa_x0", {30'd0, fwdA}, 32'd0);
    applyNop();
    tick(3);

    // Store with rd field 4 is not a producer.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 5'd1, 5'd2, 5'd4, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd4, 5'd4, 5'd13, 1'b0);
    tick(1);
    checkOutput("fa_store", {30'd0, fwdA}, 32'd0);
    checkOutput("fb_store", {30'd0, fwdB}, 32'd0);
    applyNop();
    tick(3);

    // Invalid ID slot behind a load never stalls.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd1, 5'd0, 5'd5, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd5, 5'd5, 5'd8, 1'b0);
    #1;
    checkOutput("inv_no_stall", {31'd0, stall}, 32'd0);
    applyNop();
    tick(3);

    // Flushed store never reaches MEM.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1);
    tick(1);
    checkOutput("fl_flush_cnt", flushCnt, 32'd1);
    checkOutput("fl_ex_alusrc", {31'd0, exAluSrc}, 32'd0);
    applyNop();
    tick(1);
    checkOutput("fl_mem_memwrite", {31'd0, memMemWrite}, 32'd0);
    tick(2);

    // Flush coinciding with load-use: one bubble, both counters step.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd1, 5'd0, 5'd5, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 5'd5, 5'd6, 5'd8, 1'b1);
    #1;
    checkOutput("fs_stall_on", {31'd0, stall}, 32'd1);
    tick(1);
    checkOutput("fs_stall_cnt", stallCnt, 32'd2);
    checkOutput("fs_flush_cnt", flushCnt, 32'd2);
    checkOutput("fs_ex_bubble", {30'd0, exAluOp}, 32'd0);
    checkOutput("fs_ex_branch", {31'd0, exBranch}, 32'd0);
    applyNop();
    tick(1);
    checkOutput("fs_ex_still_bubble", {30'd0, exAluOp}, 32'd0);
    checkOutput("fs_stall_cnt_hold", stallCnt, 32'd2);

    // 1-bit counters saw two stalls and two flushes: saturated at 1.
    checkOutput("sat_stall_cnt", {31'd0, stallCnt1}, 32'd1);
    checkOutput("sat_flush_cnt", {31'd0, flushCnt1}, 32'd1);

    // Reset mid-operation clears in-flight controls.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 5'd1, 5'd0, 5'd6, 1'b0);
    tick(1);
    rstN = 1'b0;
    tick(1);
    checkOutput("mid_rst_ex_aluop", {30'd0, exAluOp}, 32'd0);
    checkOutput("mid_rst_mem_memread", {31'd0, memMemRead}, 32'd0);
    checkOutput("mid_rst_stall_cnt", stallCnt, 32'd0);
    rstN = 1'b1;
    applyNop();
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
